// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with a word-serial refill/evict port.
// Define DCACHE_PERF_CNT_EN to add the hit_count/miss_count performance counter outputs.
module data_cache #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        rd_req,
  input  logic [3:0]  wr_req,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  // state      | meaning
  // IDLE       | serve hits; on a miss latch tag/set and pick write-back or refill
  // SWAP_OUT   | write the dirty victim line back, one word per mem_ack
  // SWAP_IN    | refill the line from memory, one word per mem_ack
  // SWAP_IN_OK | validate the refilled line, then return to IDLE
  typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;

  localparam int TAG_ADDR_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int WORDS        = 1 << LINE_ADDR_LEN;
  localparam int SETS         = 1 << SET_ADDR_LEN;
  localparam logic [LINE_ADDR_LEN-1:0] CNT_LAST = '1;

  state_t state_q, state_d;
  logic [LINE_ADDR_LEN-1:0] cnt_q, cnt_d;
  logic [31:0]              rd_data_q, rd_data_d;
  logic [SETS-1:0]          valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_ADDR_LEN-1:0]  lat_tag_q, lat_tag_d;
  logic [SET_ADDR_LEN-1:0]  lat_set_q, lat_set_d;
  logic [TAG_ADDR_LEN-1:0]  tag_q [SETS];
  logic [TAG_ADDR_LEN-1:0]  tag_d [SETS];
  logic [31:0]              data_q [SETS][WORDS];
  logic [31:0]              data_d [SETS][WORDS];

  logic [LINE_ADDR_LEN-1:0] off_in;
  logic [SET_ADDR_LEN-1:0]  set_in;
  logic [TAG_ADDR_LEN-1:0]  tag_in;
  logic                     active, hit;
  logic                     unused_addr_lsb;

  assign off_in = addr[2 +: LINE_ADDR_LEN];
  assign set_in = addr[2 + LINE_ADDR_LEN +: SET_ADDR_LEN];
  assign tag_in = addr[2 + LINE_ADDR_LEN + SET_ADDR_LEN +: TAG_ADDR_LEN];
  assign unused_addr_lsb = &{1'b0, addr[1:0]};

  assign active  = rd_req | (|wr_req);
  assign hit     = (state_q == IDLE) && valid_q[set_in] && (tag_q[set_in] == tag_in);
  assign rd_data = rd_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_data_q <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
      lat_tag_q <= '0;
      lat_set_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      lat_tag_q <= lat_tag_d;
      lat_set_q <= lat_set_d;
    end
  end

  // Line storage is only meaningful once valid, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (active && !hit)
                    state_d = (valid_q[set_in] && dirty_q[set_in]) ? SWAP_OUT : SWAP_IN;
      SWAP_OUT:   if (mem_ack && cnt_q == CNT_LAST) state_d = SWAP_IN;
      SWAP_IN:    if (mem_ack && cnt_q == CNT_LAST) state_d = SWAP_IN_OK;
      SWAP_IN_OK: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    miss      = active & ~hit;
    mem_req   = (state_q == SWAP_OUT) || (state_q == SWAP_IN);
    mem_we    = (state_q == SWAP_OUT);
    mem_addr  = {(state_q == SWAP_OUT) ? tag_q[lat_set_q] : lat_tag_q, lat_set_q, cnt_q, 2'b00};
    mem_wdata = data_q[lat_set_q][cnt_q];
  end

  always_comb begin
    rd_data_d = rd_data_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    lat_tag_d = lat_tag_q;
    lat_set_d = lat_set_q;
    tag_d     = tag_q;
    data_d    = data_q;
    unique case (state_q)
      IDLE: begin
        if (active && hit) begin
          // Read samples the stored word before the byte merge: read-before-write.
          if (rd_req) rd_data_d = data_q[set_in][off_in];
          for (int b = 0; b < 4; b++)
            if (wr_req[b]) data_d[set_in][off_in][8*b +: 8] = wr_data[8*b +: 8];
          if (|wr_req) dirty_d[set_in] = 1'b1;
        end else if (active) begin
          cnt_d     = '0;
          lat_tag_d = tag_in;
          lat_set_d = set_in;
        end
      end
      SWAP_OUT: if (mem_ack) cnt_d = cnt_q + 1'b1;
      SWAP_IN: if (mem_ack) begin
        data_d[lat_set_q][cnt_q] = mem_rdata;
        cnt_d = cnt_q + 1'b1;
      end
      SWAP_IN_OK: begin
        valid_d[lat_set_q] = 1'b1;
        dirty_d[lat_set_q] = 1'b0;
        tag_d[lat_set_q]   = lat_tag_q;
      end
      default: ;
    endcase
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (active && hit) hit_count_d = hit_count_q + 32'd1;
    if (state_q == IDLE && active && !hit) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed testbench for data_cache; memory responder returns mem_rdata = mem_addr and acks 2 cycles after mem_req.
module tb_data_cache;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic        rd_req = 1'b0;
  logic [3:0]  wr_req = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        miss;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] log_addr [$];
  logic [31:0] log_wdata [$];
  logic        log_we [$];

  data_cache dut (
    .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data),
    .rd_data(rd_data), .miss(miss), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        mem_ack = 1'b0;
        wait_cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        wait_cnt = 0;
      end else if (mem_req) begin
        wait_cnt++;
        if (wait_cnt == 2) begin
          mem_ack = 1'b1;
          mem_rdata = mem_addr;
          log_addr.push_back(mem_addr);
          log_we.push_back(mem_we);
          log_wdata.push_back(mem_wdata);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_wdata.delete();
  endtask

  task automatic run_req(input logic [31:0] a, input logic rd, input logic [3:0] we,
                         input logic [31:0] wd, output logic saw_miss, output logic timed_out);
    int n;
    @(negedge clk);
    addr = a; rd_req = rd; wr_req = we; wr_data = wd;
    #1;
    saw_miss = miss;
    n = 0;
    while (miss && n < 300) begin
      @(negedge clk);
      n++;
    end
    timed_out = miss;
    @(posedge clk);
    #1;
    rd_req = 1'b0; wr_req = '0;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    tests_run++;
    if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL reset_rd_data: got %h want 00000000", rd_data); end
    tests_run++;
    if (miss !== 1'b0) begin tests_failed++; $display("FAIL reset_miss: got %b want 0", miss); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_refill();
    logic sm, to;
    clear_log();
    run_req(32'h40, 1'b1, 4'b0, 32'h0, sm, to);
    tests_run++;
    if (sm !== 1'b1) begin tests_failed++; $display("FAIL refill_miss_now: got %b want 1", sm); end
    tests_run++;
    if (to !== 1'b0) begin tests_failed++; $display("FAIL refill_timeout: miss stuck high"); end
    tests_run++;
    if (log_addr.size() != 8) begin tests_failed++; $display("FAIL refill_beats: got %0d want 8", log_addr.size()); end
    for (int i = 0; i < log_addr.size() && i < 8; i++) begin
      tests_run++;
      if (log_addr[i] !== 32'h40 + 32'(4*i) || log_we[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL refill_beat%0d: got addr %h we %b want addr %h we 0", i, log_addr[i], log_we[i], 32'h40 + 32'(4*i));
      end
    end
    tests_run++;
    if (rd_data !== 32'h40) begin tests_failed++; $display("FAIL refill_rd_data: got %h want 00000040", rd_data); end
  endtask

  task automatic test_write_hit();
    logic sm, to;
    clear_log();
    run_req(32'h44, 1'b0, 4'b0010, 32'h0000AB00, sm, to);
    tests_run++;
    if (sm !== 1'b0 || log_addr.size() != 0) begin
      tests_failed++; $display("FAIL write_hit: got miss %b beats %0d want miss 0 beats 0", sm, log_addr.size());
    end
    run_req(32'h44, 1'b1, 4'b0, 32'h0, sm, to);
    tests_run++;
    if (rd_data !== 32'h0000AB44) begin tests_failed++; $display("FAIL write_merge: got %h want 0000ab44", rd_data); end
    run_req(32'h48, 1'b1, 4'b0001, 32'h000000FF, sm, to);
    tests_run++;
    if (rd_data !== 32'h00000048) begin tests_failed++; $display("FAIL read_before_write: got %h want 00000048", rd_data); end
    run_req(32'h48, 1'b1, 4'b0, 32'h0, sm, to);
    tests_run++;
    if (rd_data !== 32'h000000FF || log_addr.size() != 0) begin
      tests_failed++; $display("FAIL rw_write_applied: got %h beats %0d want 000000ff beats 0", rd_data, log_addr.size());
    end
  endtask

  task automatic test_dirty_evict();
    logic sm, to;
    logic [31:0] exp_a, exp_d;
    clear_log();
    run_req(32'hC4, 1'b1, 4'b0, 32'h0, sm, to);
    tests_run++;
    if (sm !== 1'b1 || to !== 1'b0) begin tests_failed++; $display("FAIL evict_miss: got miss %b timeout %b want 1 0", sm, to); end
    tests_run++;
    if (log_addr.size() != 16) begin tests_failed++; $display("FAIL evict_beats: got %0d want 16", log_addr.size()); end
    for (int i = 0; i < log_addr.size() && i < 16; i++) begin
      if (i < 8) begin
        exp_a = 32'h40 + 32'(4*i);
        exp_d = (exp_a == 32'h44) ? 32'h0000AB44 : (exp_a == 32'h48) ? 32'h000000FF : exp_a;
        tests_run++;
        if (log_we[i] !== 1'b1 || log_addr[i] !== exp_a || log_wdata[i] !== exp_d) begin
          tests_failed++;
          $display("FAIL evict_wr%0d: got we %b addr %h data %h want we 1 addr %h data %h", i, log_we[i], log_addr[i], log_wdata[i], exp_a, exp_d);
        end
      end else begin
        exp_a = 32'hC0 + 32'(4*(i-8));
        tests_run++;
        if (log_we[i] !== 1'b0 || log_addr[i] !== exp_a) begin
          tests_failed++;
          $display("FAIL evict_rd%0d: got we %b addr %h want we 0 addr %h", i, log_we[i], log_addr[i], exp_a);
        end
      end
    end
    tests_run++;
    if (rd_data !== 32'hC4) begin tests_failed++; $display("FAIL evict_rd_data: got %h want 000000c4", rd_data); end
  endtask

  task automatic test_clean_conflict();
    logic sm, to;
    clear_log();
    run_req(32'h144, 1'b1, 4'b0, 32'h0, sm, to);
    tests_run++;
    if (log_addr.size() != 8 || to !== 1'b0) begin tests_failed++; $display("FAIL clean_beats: got %0d want 8", log_addr.size()); end
    for (int i = 0; i < log_addr.size() && i < 8; i++) begin
      tests_run++;
      if (log_we[i] !== 1'b0 || log_addr[i] !== 32'h140 + 32'(4*i)) begin
        tests_failed++;
        $display("FAIL clean_beat%0d: got we %b addr %h want we 0 addr %h", i, log_we[i], log_addr[i], 32'h140 + 32'(4*i));
      end
    end
    tests_run++;
    if (rd_data !== 32'h144) begin tests_failed++; $display("FAIL clean_rd_data: got %h want 00000144", rd_data); end
`ifdef DCACHE_PERF_CNT_EN
    tests_run++;
    if (miss_count !== 32'd3) begin tests_failed++; $display("FAIL miss_count: got %0d want 3", miss_count); end
    tests_run++;
    if (hit_count !== 32'd7) begin tests_failed++; $display("FAIL hit_count: got %0d want 7", hit_count); end
`endif
  endtask

  task automatic test_reset_mid_refill();
    logic sm, to;
    int n;
    clear_log();
    @(negedge clk);
    addr = 32'h40; rd_req = 1'b1;
    n = 0;
    while (log_addr.size() < 3 && n < 300) begin
      @(posedge clk);
      n++;
    end
    tests_run++;
    if (log_addr.size() < 3) begin tests_failed++; $display("FAIL midrst_wait: got %0d beats want 3", log_addr.size()); end
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL midrst_mem_req: got %b want 0", mem_req); end
    tests_run++;
    if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL midrst_rd_data: got %h want 00000000", rd_data); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    rst = 1'b1;
    addr = 32'h144;
    rd_req = 1'b1;
    #1;
    tests_run++;
    if (miss !== 1'b1) begin tests_failed++; $display("FAIL release_invalid: got miss %b want 1", miss); end
    rd_req = 1'b0;
    clear_log();
    run_req(32'h40, 1'b1, 4'b0, 32'h0, sm, to);
    tests_run++;
    if (sm !== 1'b1 || to !== 1'b0 || log_addr.size() != 8) begin
      tests_failed++; $display("FAIL midrst_refill: got miss %b beats %0d want miss 1 beats 8", sm, log_addr.size());
    end
    for (int i = 0; i < log_addr.size() && i < 8; i++) begin
      tests_run++;
      if (log_we[i] !== 1'b0 || log_addr[i] !== 32'h40 + 32'(4*i)) begin
        tests_failed++;
        $display("FAIL midrst_beat%0d: got we %b addr %h want we 0 addr %h", i, log_we[i], log_addr[i], 32'h40 + 32'(4*i));
      end
    end
    tests_run++;
    if (rd_data !== 32'h40) begin tests_failed++; $display("FAIL midrst_rd_data: got %h want 00000040", rd_data); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if (miss !== 1'b0 || mem_req !== 1'b0 || rd_data !== 32'h40) begin
        tests_failed++;
        $display("FAIL idle_cycle%0d: got miss %b mem_req %b rd_data %h want 0 0 00000040", i, miss, mem_req, rd_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_write_hit();
    test_dirty_evict();
    test_clean_conflict();
    test_reset_mid_refill();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache.
- Sits in the MEM stage. It is instantiated inside the MEM/WB write-back data segment register and feeds that register's data-extension logic.
- Produces synchronous word reads (data valid the cycle after the request) and a combinational miss signal, which the hazard unit uses to stall the pipeline.
- Refills and evicts lines over a word-serial req/ack main-memory port.

Parameters:
- LINE_ADDR_LEN, 3: log2(words per line); default gives 8 words, 32 bytes per line.
- SET_ADDR_LEN, 2: log2(number of sets); default gives 4 sets.
- Derived localparam TAG_ADDR_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  32  byte address. Fields: addr[1:0] ignored, then word offset, set, tag.
- rd_req  in  1  read request.
- wr_req  in  4  byte write enables, already lane-shifted; 0 means no write.
- wr_data  in  32  write data, already lane-aligned.
- rd_data  out  32  registered read word.
- miss  out  1  combinational; high means the request cannot complete, so stall.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  1 = write (evict), 0 = read (refill).
- mem_addr  out  32  word-aligned byte address of the current word.
- mem_wdata  out  32  eviction write data.
- mem_rdata  in  32  refill read data; valid when mem_ack is high.
- mem_ack  in  1  one-cycle pulse; current word done.

Behaviour:
- Storage per set: valid bit, dirty bit, tag, and 2^LINE_ADDR_LEN words.
- FSM states: IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK.
- Active request: rd_req=1 or wr_req!=0.
- Hit: state==IDLE, line valid, and tag matches.
- miss = active & ~hit, combinational, in every state. miss stays 1 through SWAP_OUT, SWAP_IN and SWAP_IN_OK.
- The pipeline holds addr, rd_req, wr_req and wr_data stable while miss=1. The cache still latches tag and set at miss entry and uses only the latched copy during the swap.
- Read hit: rd_data <= selected word at the next edge, i.e. 1-cycle latency.
- Write hit: merge enabled bytes at the next edge; dirty <= 1.
- Read and write active together on a hit: rd_data returns the pre-write word (read-before-write); the write still applies.
- No active request: miss=0, no state change, rd_data holds its value. rd_data also holds during misses.
- IDLE with a miss:
  - If the victim is valid and dirty, go to SWAP_OUT; otherwise go to SWAP_IN. Word counter cnt <= 0.
- SWAP_OUT:
  - mem_req=1, mem_we=1.
  - mem_addr = {victim tag, set, cnt, 2'b00}; mem_wdata = victim word[cnt].
  - On each mem_ack, cnt++.
  - On the ack of the last word (cnt = 2^LINE-1), go to SWAP_IN with cnt <= 0.
- SWAP_IN:
  - mem_req=1, mem_we=0, mem_addr = {new tag, set, cnt, 2'b00}.
  - On each mem_ack, word[cnt] <= mem_rdata and cnt++.
  - After the last word, go to SWAP_IN_OK.
- SWAP_IN_OK: valid <= 1, tag <= new tag, dirty <= 0, then go to IDLE.
- Back in IDLE the held request is a hit; miss drops and it completes as a normal hit one edge later.
- mem_req is 0 in IDLE and SWAP_IN_OK. mem_addr and mem_wdata are don't-care when mem_req=0.
- mem_ack while mem_req=0 is ignored.
- Counter wrap: cnt is LINE_ADDR_LEN bits; completion is detected on an ack at the all-ones value. There is no extra beat.
- Reset (asynchronous assert, any state, including mid-swap):
  - state=IDLE; all valid and dirty bits 0; cnt=0; rd_data=0; mem_req=0.
  - A partially refilled line is never validated.
  - A partial write-back is abandoned; memory contents are then undefined for that line.
- Reset release: a request presented during the first clock after release sees an all-invalid cache.

Optional Feature:
- Macro: DCACHE_PERF_CNT_EN.
- When defined, adds two output ports, hit_count[31:0] and miss_count[31:0]. Both reset to 0 and wrap modulo 2^32.
  - hit_count increments once per edge with an active request that hits.
  - miss_count increments once per IDLE-to-swap transition; a stalled request counts as one miss, not one per stall cycle.
- When undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
All cases use default parameters: set = addr[6:5]; the memory model returns mem_rdata = mem_addr, and acks each word 2 cycles after mem_req.

1. After reset, rd_req=1, addr=0x40 → miss=1 in the same cycle; 8 reads at mem_addr 0x40..0x5C with mem_we=0; then SWAP_IN_OK; miss=0 in IDLE; rd_data=0x00000040 one edge later.
2. Write hit: wr_req=4'b0010, wr_data=0x0000AB00, addr=0x44 → miss=0, no memory traffic. A read of 0x44 then returns 0x0000AB44.
3. Dirty conflict: read 0xC4 (set 2) → 8 writes at 0x40..0x5C, with the beat at 0x44 carrying mem_wdata=0x0000AB44; then 8 reads at 0xC0..0xDC; rd_data=0x000000C4.
4. Clean conflict: read 0x144 → no write beats, 8 reads at 0x140..0x15C only. With DCACHE_PERF_CNT_EN, miss_count=3 after this step.
5. Reset mid-refill: drive rst=0 after the 3rd ack of a refill → mem_req=0 immediately. After release, a read of 0x40 misses again and issues a full 8-beat refill.
6. Idle: rd_req=0, wr_req=0 for 10 cycles → miss=0, mem_req=0 throughout, rd_data unchanged.
